// File: rtl/oled_digit_streamer_pkg.sv
// Shared display definitions for the 7-segment OLED character path.
package oled_digit_streamer_pkg;

    // One bit per segment a..g (bit 0 = a).
    localparam int unsigned SEG_W          = 7;
    localparam int unsigned CHAR_W         = 16;
    localparam int unsigned PAGE_H         = 8;
    localparam int unsigned DEF_NUM_DIGITS = 8;
    localparam int unsigned DEF_PAGES      = 4;

    typedef logic [SEG_W-1:0] segments_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/oled_digit_streamer.sv
// Streams one SSD1306 frame (horizontal addressing) of rendered 7-segment digits.
// The column decoder lives outside; this block drives its inputs and registers its byte.
module oled_digit_streamer
    import oled_digit_streamer_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int unsigned PAGES      = DEF_PAGES
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       frame_start,
    input  segments_t [NUM_DIGITS-1:0] segments_in,
    output segments_t                  dec_segments,
    output logic [3:0]                 dec_index_x,
    output logic [1:0]                 dec_index_y,
    input  logic [7:0]                 dec_pix_column,
    output logic [7:0]                 data_out,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic                       data_last,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int unsigned COLS       = NUM_DIGITS * CHAR_W;
    localparam int unsigned COL_W      = $clog2(COLS);
    localparam int unsigned PAGE_W     = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int unsigned DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CHAR_SHIFT = $clog2(CHAR_W);

    state_e                     state_q, state_d;
    logic [COL_W-1:0]           col_q, col_d;
    logic [PAGE_W-1:0]          page_q, page_d;
    segments_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [7:0]                 data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       last_q, last_d;
    logic                       loaded_q, loaded_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [DIG_W-1:0]           digit_c;
    logic                       col_end_c;
    logic                       page_end_c;
    logic                       accept_c;

    assign digit_c    = DIG_W'(col_q >> CHAR_SHIFT);
    assign col_end_c  = (col_q == COL_W'(COLS - 1));
    assign page_end_c = (page_q == PAGE_W'(PAGES - 1));
    assign accept_c   = valid_q && data_ready;

    // Decoder request: current cell from the shadow copy, or the home cell when idle.
    always_comb begin
        dec_segments = shadow_q[0];
        dec_index_x  = 4'd0;
        dec_index_y  = 2'd0;
        if (state_q != ST_IDLE) begin
            dec_segments = shadow_q[digit_c];
            dec_index_x  = 4'(col_q);
            dec_index_y  = 2'(page_q);
        end
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        page_d   = page_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        loaded_d = loaded_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    shadow_d = segments_in;
                    col_d    = '0;
                    page_d   = '0;
                    loaded_d = 1'b0;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept_c) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
                // loaded_q marks that the final byte has already been taken from the decoder.
                if (!loaded_q && (!valid_q || data_ready)) begin
                    data_d  = dec_pix_column;
                    valid_d = 1'b1;
                    last_d  = col_end_c && page_end_c;
                    if (col_end_c) begin
                        col_d = '0;
                        if (page_end_c) begin
                            loaded_d = 1'b1;
                        end else begin
                            page_d = page_q + PAGE_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                if (accept_c && last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            page_q   <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            loaded_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            page_q   <= page_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            loaded_q <= loaded_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign data_last  = last_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: doc/oled_digit_streamer.md
OLED_DIGIT_STREAMER -- requirements
Module: oled_digit_streamer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of 16-column character cells per display row.
REQ-002 SHALL have parameter PAGES, default 4, number of 8-pixel SSD1306 pages (32-pixel-high panel).
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle request to stream one full frame.
REQ-006 SHALL have port segments_in  input  NUM_DIGITS x Segments  per-digit segment sets; element 0 is the leftmost digit.
REQ-007 SHALL have port dec_segments  output  Segments  segment set of the digit currently being decoded.
REQ-008 SHALL have port dec_index_x  output  4  column within the character cell, 0..15.
REQ-009 SHALL have port dec_index_y  output  2  page index, 0..PAGES-1.
REQ-010 SHALL have port dec_pix_column  input  8  combinational pixel byte returned by the 7-seg column decoder.
REQ-011 SHALL have port data_out  output  8  display RAM byte toward the SSD1306 transport.
REQ-012 SHALL have port data_valid  output  1  data_out holds a valid byte.
REQ-013 SHALL have port data_ready  input  1  transport accepts the byte this cycle.
REQ-014 SHALL have port data_last  output  1  qualifies the final byte of the frame.
REQ-015 SHALL have port busy  output  1  frame in progress.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-017 SHALL implement states IDLE, STREAM, DONE.
REQ-018 In IDLE, frame_start high SHALL latch all segments_in into an internal shadow register, clear the counters, and enter STREAM on the same edge.
REQ-019 The frame SHALL be exactly NUM_DIGITS*16*PAGES bytes (512 by default), in SSD1306 horizontal addressing order: page 0 columns 0..N-1, then page 1, and so on.
REQ-020 The column counter col SHALL drive the decoder: digit = col / 16, dec_index_x = col mod 16, dec_index_y = page, dec_segments = shadow[digit].
REQ-021 The decoder outputs SHALL come only from the shadow register, so segments_in changes during a frame SHALL NOT affect the frame.
REQ-022 The output register SHALL load dec_pix_column and advance the counters when (!data_valid || data_ready) and bytes remain; the first byte SHALL be valid on the cycle after the STREAM entry edge.
REQ-023 data_out, data_valid and data_last SHALL stay stable while data_valid && !data_ready.
REQ-024 When col reaches NUM_DIGITS*16-1, col SHALL wrap to 0 and page SHALL increment.
REQ-025 data_last SHALL be high only with byte index NUM_DIGITS*16*PAGES-1.
REQ-026 Acceptance of the last byte (data_valid && data_ready && data_last) SHALL move to DONE; DONE SHALL assert frame_done for one cycle, then return to IDLE.
REQ-027 busy SHALL be high in STREAM and DONE.
REQ-028 frame_start in STREAM or DONE, including the cycle the last byte is accepted, SHALL be ignored and not queued.
REQ-029 Outside IDLE, dec_* outputs SHALL be driven as in REQ-020; in IDLE they SHALL present digit 0, x=0, y=0.

Reset
REQ-030 resetn low SHALL immediately force IDLE, data_valid=0, data_last=0, busy=0, frame_done=0, data_out=0, counters=0, shadow=0.
REQ-031 Reset mid-frame SHALL abandon the frame with no further bytes and no frame_done.

Structure
REQ-032 Segments typedef, character width (16), page height (8) and default NUM_DIGITS/PAGES SHALL live in the shared display package.
REQ-033 The block SHALL NOT instantiate the decoder; the parent connects dec_* and dec_pix_column to it. No sub-module is required.

Verification
REQ-034 Reset, then frame_start with data_ready held high -> 512 consecutive valid bytes from cycle 1, data_last on byte 511, frame_done one cycle later, busy low after.
REQ-035 digit 0 = all segments, others = 0 -> bytes 0..15 of every page match the decoder model for digit 0; all other bytes = 8'h00.
REQ-036 data_ready toggled randomly at 50% -> data_out stable while stalled; byte sequence identical to the unstalled run.
REQ-037 segments_in changed at byte 100 -> whole frame reflects the segments latched at frame_start.
REQ-038 frame_start pulsed at byte 200 and on the last-acceptance cycle -> ignored; exactly one frame and one frame_done.
REQ-039 resetn asserted at byte 300 -> data_valid low immediately; next frame_start yields a full 512-byte frame from byte 0.
